// File: rtl/audio_player.sv
// Buffers 8-bit audio bytes in a circular FIFO and plays them as PWM, one sample per tick.
// Push seen in fifo_count after 1 cycle; no backpressure: bytes arriving while full are dropped (sticky overflow).
module audio_player #(
    parameter int SAMPLE_DIV  = 6250,
    parameter int FIFO_DEPTH  = 64,
    parameter int START_LEVEL = 32
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        audio_axiiv,
    input  logic [7:0]                  audio_axiid,
    output logic                        pwm_out,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        playing,
    output logic                        overflow,
    output logic                        underrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
    localparam logic [AW:0]   DEPTH_C   = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   START_C   = (AW+1)'(START_LEVEL);
    localparam logic [7:0]    SILENCE   = 8'd128;

    typedef enum logic {BUFFER = 1'b0, PLAY = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [7:0]    pwm_cnt_q, pwm_cnt_d;
    logic [7:0]    cur_sample_q, cur_sample_d;
    logic          pwm_out_q, pwm_out_d;
    logic          overflow_q, overflow_d;
    logic          underrun_q, underrun_d;
    logic [7:0]    mem [FIFO_DEPTH];

    logic tick;
    logic pop;
    logic starve;
    logic push;

    assign tick = (tick_cnt_q == TICK_LAST);
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a byte on a pop tick.
    assign push = audio_axiiv && ((count_q < DEPTH_C) || pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= BUFFER;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BUFFER:  if (count_q >= START_C) state_d = PLAY;
            PLAY:    if (tick && (count_q == '0)) state_d = BUFFER;
            default: state_d = BUFFER;
        endcase
    end

    always_comb begin
        pop    = 1'b0;
        starve = 1'b0;
        if (state_q == PLAY && tick) begin
            pop    = (count_q != '0);
            starve = (count_q == '0);
        end
    end

    always_comb begin
        wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d      = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        tick_cnt_d   = tick ? '0 : tick_cnt_q + TW'(1);
        pwm_cnt_d    = pwm_cnt_q + 8'd1;
        cur_sample_d = cur_sample_q;
        if (pop) begin
            cur_sample_d = mem[rd_ptr_q];
        end else if (starve) begin
            cur_sample_d = SILENCE;
        end
        pwm_out_d    = (pwm_cnt_q < cur_sample_q);
        overflow_d   = overflow_q || (audio_axiiv && !push);
        underrun_d   = starve;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            tick_cnt_q   <= '0;
            pwm_cnt_q    <= '0;
            cur_sample_q <= SILENCE;
            pwm_out_q    <= 1'b0;
            overflow_q   <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            tick_cnt_q   <= tick_cnt_d;
            pwm_cnt_q    <= pwm_cnt_d;
            cur_sample_q <= cur_sample_d;
            pwm_out_q    <= pwm_out_d;
            overflow_q   <= overflow_d;
            underrun_q   <= underrun_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= audio_axiid;
        end
    end

    assign pwm_out    = pwm_out_q;
    assign fifo_count = count_q;
    assign playing    = (state_q == PLAY);
    assign overflow   = overflow_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_audio_player.sv
// Bench for audio_player: scoreboard of pushed samples checked against PWM duty per tick.
module tb_audio_player;

    localparam int SD    = 400;
    localparam int DEPTH = 64;
    localparam int START = 32;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       vld  = 1'b0;
    logic [7:0] dat  = 8'd0;
    logic       pwm_out, playing, overflow, underrun;
    logic [6:0] fifo_count;

    logic       vld2 = 1'b0;
    logic [7:0] dat2 = 8'd0;
    logic       pwm2, play2, ovf2, und2;
    logic [6:0] cnt2;

    audio_player #(.SAMPLE_DIV(SD), .FIFO_DEPTH(DEPTH), .START_LEVEL(START)) dut (
        .clk(clk), .rstn(rstn), .audio_axiiv(vld), .audio_axiid(dat),
        .pwm_out(pwm_out), .fifo_count(fifo_count), .playing(playing),
        .overflow(overflow), .underrun(underrun)
    );

    // Tick held off for the whole run so nothing is ever popped.
    audio_player #(.SAMPLE_DIV(1 << 20), .FIFO_DEPTH(DEPTH), .START_LEVEL(64)) dut_ovf (
        .clk(clk), .rstn(rstn), .audio_axiiv(vld2), .audio_axiid(dat2),
        .pwm_out(pwm2), .fifo_count(cnt2), .playing(play2),
        .overflow(ovf2), .underrun(und2)
    );

    always #10 clk = ~clk;

    int cyc;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    int und_cnt = 0;
    always @(negedge clk) begin
        if (underrun) und_cnt <= und_cnt + 1;
    end

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];
    logic [7:0] e, b;
    int h, base;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        vld  = 1'b0;
        vld2 = 1'b0;
        repeat (3) step();
        rstn = 1'b1;
    endtask

    task automatic push(input logic [7:0] v);
        vld = 1'b1;
        dat = v;
        step();
        vld = 1'b0;
        if (exp_q.size() < DEPTH) exp_q.push_back(v);
    endtask

    task automatic wait_tick(input string tag);
        for (int n = 0; n < SD + 2; n++) begin
            step();
            if (cyc % SD == 0) break;
        end
        check(tag, cyc % SD, 0);
    endtask

    task automatic duty(output int hi);
        hi = 0;
        repeat (2) step();
        repeat (256) begin
            step();
            hi += int'(pwm_out);
        end
    endtask

    initial begin
        #(90000 * 20);
        $display("FAIL timeout: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        do_reset();
        check("rst_playing", playing, 0);
        check("rst_count", fifo_count, 0);
        check("rst_pwm", pwm_out, 0);
        check("rst_overflow", overflow, 0);
        check("rst_underrun", underrun, 0);

        // Overflow: no pops, 70 bytes into a 64-entry FIFO.
        for (int i = 0; i < 70; i++) begin
            vld2 = 1'b1;
            dat2 = 8'(i);
            step();
            check("ovf_count", cnt2, (i + 1 > DEPTH) ? DEPTH : i + 1);
            check("ovf_flag", ovf2, (i >= DEPTH) ? 1 : 0);
        end
        vld2 = 1'b0;
        repeat (20) step();
        check("ovf_sticky", ovf2, 1);
        check("ovf_count_hold", cnt2, DEPTH);

        // Idle: silence duty, no playback, no underrun.
        base = und_cnt;
        repeat (10000) step();
        duty(h);
        check("idle_duty", h, 128);
        check("idle_playing", playing, 0);
        check("idle_count", fifo_count, 0);
        check("idle_underrun", und_cnt - base, 0);

        // Fill to start level, play out all 32, then starve.
        do_reset();
        exp_q.delete();
        base = und_cnt;
        for (int i = 0; i < START; i++) begin
            b = (i == 0) ? 8'hC0 : (i == 1) ? 8'hFF : (i == 2) ? 8'h00 : 8'($urandom_range(1, 254));
            push(b);
        end
        check("b_count_full", fifo_count, START);
        check("b_play_before", playing, 0);
        step();
        check("b_play_start", playing, 1);
        while (cyc < SD - 1) step();
        check("b_pre_tick", fifo_count, START);
        step();
        for (int k = 0; k < START; k++) begin
            if (k > 0) wait_tick("b_tick");
            e = exp_q.pop_front();
            check("b_count", fifo_count, exp_q.size());
            check("b_playing", playing, 1);
            duty(h);
            check("b_duty", h, int'(e));
        end
        check("b_no_underrun_yet", und_cnt - base, 0);
        wait_tick("b_tick33");
        check("b_underrun", underrun, 1);
        check("b_play_off", playing, 0);
        check("b_count_empty", fifo_count, 0);
        step();
        check("b_underrun_pulse", underrun, 0);
        duty(h);
        check("b_duty_silence", h, 128);
        check("b_underrun_count", und_cnt - base, 1);

        // Full FIFO with a push coincident with a tick pop, then drain across the wrap.
        do_reset();
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) push(8'(i * 3 + 5));
        check("c_count_full", fifo_count, DEPTH);
        check("c_playing", playing, 1);
        check("c_overflow0", overflow, 0);
        while (cyc % SD != SD - 1) step();
        vld = 1'b1;
        dat = 8'hAB;
        step();
        vld = 1'b0;
        e = exp_q.pop_front();
        exp_q.push_back(8'hAB);
        check("c_count_same", fifo_count, DEPTH);
        check("c_overflow_same", overflow, 0);
        duty(h);
        check("c_duty_oldest", h, int'(e));
        for (int k = 0; k < DEPTH; k++) begin
            wait_tick("c_tick");
            e = exp_q.pop_front();
            check("c_count", fifo_count, exp_q.size());
            duty(h);
            check("c_duty", h, int'(e));
        end

        // Asynchronous reset mid-playback with 20 queued.
        do_reset();
        exp_q.delete();
        for (int i = 0; i < START; i++) push(8'(i + 100));
        step();
        repeat (12) begin
            wait_tick("d_tick");
            e = exp_q.pop_front();
        end
        check("d_count20", fifo_count, 20);
        check("d_playing", playing, 1);
        #3;
        rstn = 1'b0;
        #1;
        check("d_async_playing", playing, 0);
        check("d_async_count", fifo_count, 0);
        check("d_async_pwm", pwm_out, 0);
        check("d_async_overflow", overflow, 0);
        check("d_async_underrun", underrun, 0);
        repeat (3) step();
        rstn = 1'b1;
        exp_q.delete();
        step();
        check("d_after_count", fifo_count, 0);
        check("d_after_playing", playing, 0);
        duty(h);
        check("d_after_duty", h, 128);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_player.md
AUDIO_PLAYER -- requirements
Module: audio_player

Interface
REQ-001 The block SHALL have parameter SAMPLE_DIV, default 6250, meaning clk cycles per audio sample (50 MHz / 8 kHz).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 64, meaning sample FIFO entries (power of two, at least 4).
REQ-003 The block SHALL have parameter START_LEVEL, default 32, meaning FIFO occupancy required before playback starts (1 to FIFO_DEPTH).
REQ-004 Port: clk  input  1  Ethernet reference clock, 50 MHz; sole clock.
REQ-005 Port: rstn  input  1  Reset, asynchronous, active-low.
REQ-006 Port: audio_axiiv  input  1  Audio byte valid, from image_audio_splitter.
REQ-007 Port: audio_axiid  input  8  Unsigned audio sample, 128 = silence.
REQ-008 Port: pwm_out  output  1  Registered PWM audio output.
REQ-009 Port: fifo_count  output  $clog2(FIFO_DEPTH)+1  Current FIFO occupancy.
REQ-010 Port: playing  output  1  High while in PLAY state.
REQ-011 Port: overflow  output  1  Sticky; set when a valid byte is dropped; cleared only by reset.
REQ-012 Port: underrun  output  1  One-cycle pulse on a sample tick in PLAY with an empty FIFO.

Function
REQ-013 The FIFO SHALL be circular, with read and write pointers wrapping modulo FIFO_DEPTH and no bubble at wrap.
REQ-014 On a cycle with audio_axiiv high, the sample SHALL be written if fifo_count < FIFO_DEPTH or a pop occurs in the same cycle; otherwise it SHALL be dropped and overflow set.
REQ-015 A written sample SHALL be reflected in fifo_count on the next clk edge (latency 1).
REQ-016 A free-running tick counter SHALL count 0..SAMPLE_DIV-1 and wrap; tick is asserted while the counter equals SAMPLE_DIV-1.
REQ-017 The state machine SHALL have exactly two states, BUFFER and PLAY.
REQ-018 The block SHALL move from BUFFER to PLAY on the edge after fifo_count >= START_LEVEL; fifo_count SHALL NOT be popped while in BUFFER.
REQ-019 In PLAY, on tick with fifo_count > 0, the block SHALL pop one sample into cur_sample at the same edge.
REQ-020 In PLAY, on tick with fifo_count == 0, the block SHALL pulse underrun, set cur_sample to 128, and return to BUFFER.
REQ-021 When push and pop occur on the same cycle, fifo_count SHALL be unchanged, and the popped value SHALL be the oldest entry, never the one being written.
REQ-022 An 8-bit PWM counter SHALL free-run 0..255; pwm_out SHALL be registered as (pwm_cnt < cur_sample).
REQ-023 cur_sample 0 SHALL give constant low; cur_sample 255 SHALL give high 255 of every 256 cycles.
REQ-024 playing SHALL equal (state == PLAY).
REQ-025 fifo_count SHALL never exceed FIFO_DEPTH and never underflow.

Reset
REQ-026 While rstn is low, asynchronously: state=BUFFER, pointers=0, fifo_count=0, tick counter=0, pwm_cnt=0, cur_sample=128, pwm_out=0, playing=0, overflow=0, underrun=0.
REQ-027 Reset asserted mid-playback SHALL discard all FIFO contents; FIFO RAM contents need not be cleared.
REQ-028 After rstn deasserts, the first sample tick SHALL occur SAMPLE_DIV cycles later.

Verification
REQ-029 Reset, no input for 10000 cycles -> playing=0, fifo_count=0, pwm_out high 128 of every 256 cycles, underrun never pulses.
REQ-030 Push 32 bytes of 0xC0 back-to-back -> fifo_count=32 one cycle after the last push; playing=1 on the following edge; at the first tick, fifo_count drops to 31 and pwm duty becomes 192/256.
REQ-031 Push 70 bytes with no playback (START_LEVEL=64 variant, held off via SAMPLE_DIV large) -> fifo_count saturates at 64; overflow=1 after the 65th byte and stays 1.
REQ-032 Reach PLAY with 32 samples then stop input -> exactly 32 pops at SAMPLE_DIV spacing; on the 33rd tick underrun pulses for one cycle, playing=0, cur_sample=128.
REQ-033 Full FIFO with push coincident with a tick pop -> byte accepted, fifo_count stays 64, overflow stays 0, popped value is the oldest entry.
REQ-034 Drive rstn low for 3 cycles mid-PLAY with 20 queued -> all outputs at reset values immediately (asynchronous), fifo_count=0 after release.
